regfile_write_arbiter: RTL

//  Shares the single register-file write port (dataIn/dataInRegister/enableSavingDataIn)

---
 rtl/regfile_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// sources (ALU, load unit, ...). Arbitration is round-robin. A requester may
// optionally lock the grant for a burst of up to MAX_BURST consecutive beats.
// The accepted write is registered for one cycle before it reaches the
// register file.
//
// Parameters
//   DATA_W     write data width
//   ADDR_W     register index width
//   NUM_REQ    number of requesters (2..4)
//   MAX_BURST  max consecutive grants to a locked requester (1..15)
//
// Ports
//   clk                 in   rising-edge clock
//   rst_n               in   asynchronous active-low reset
//   reqValid            in   [NUM_REQ]   requester i has a write pending
//   reqLock             in   [NUM_REQ]   requester i wants to keep the grant
//   reqData             in   [NUM_REQ*DATA_W] write data, slice i
//   reqReg              in   [NUM_REQ*ADDR_W] target register, slice i
//   reqReady            out  [NUM_REQ]   one-hot (or zero) grant, combinational
//   dataIn              out  [DATA_W]    registered write data
//   dataInRegister      out  [ADDR_W]    registered write index
//   enableSavingDataIn  out  1           registered write enable
//   burstActive         out  1           high while the arbiter is in a burst
//
// Optional feature macro: REGARB_HAZARD_EN
//   When defined, this adds the inputs dataOutRegisterA/B [ADDR_W] and the
//   combinational outputs hazardA/hazardB. hazardX flags a read port whose
//   index matches either a write accepted this cycle or the registered write
//   that the register file has not yet committed.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ-1:0]        reqLock,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic [NUM_REQ*ADDR_W-1:0] reqReg,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic [DATA_W-1:0]         dataIn,
  output logic [ADDR_W-1:0]         dataInRegister,
  output logic                      enableSavingDataIn,
  output logic                      burstActive
`ifdef REGARB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0]         dataOutRegisterA,
  input  logic [ADDR_W-1:0]         dataOutRegisterB,
  output logic                      hazardA,
  output logic                      hazardB
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  arb_state_e               state_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         owner_q;
  logic [3:0]               burst_cnt_q;
  logic [DATA_W-1:0]        data_q;
  logic [ADDR_W-1:0]        reg_q;
  logic                     we_q;
  logic                     burst_active_q;

  logic [NUM_REQ-1:0]       gnt_s;
  logic [PTR_W-1:0]         gnt_idx_s;
  logic                     gnt_found_s;
  logic [DATA_W-1:0]        gnt_data_s;
  logic [ADDR_W-1:0]        gnt_reg_s;
  logic [PTR_W-1:0]         rr_next_s;
  logic                     burst_last_s;

  // Index (base + ofs) mod NUM_REQ; ofs never exceeds NUM_REQ-1.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Grant selection: in a burst only the owner can win, otherwise search
  // round-robin from rr_ptr_q. No grant at all while reset is asserted.
  always_comb begin
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    if (!rst_n) begin
      gnt_found_s = 1'b0;
    end else if (state_q == ARB_BURST) begin
      if (reqValid[owner_q]) begin
        gnt_idx_s   = owner_q;
        gnt_found_s = 1'b1;
      end else begin
        gnt_found_s = 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_found_s && reqValid[rr_index(rr_ptr_q, k)]) begin
          gnt_idx_s   = rr_index(rr_ptr_q, k);
          gnt_found_s = 1'b1;
        end else begin
          gnt_found_s = gnt_found_s;
        end
      end
    end
  end

  // One-hot grant vector and the selected write payload.
  always_comb begin
    gnt_s = '0;
    if (gnt_found_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
    gnt_data_s = reqData[int'(gnt_idx_s)*DATA_W +: DATA_W];
    gnt_reg_s  = reqReg[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
    rr_next_s  = rr_index(gnt_idx_s, 1);
  end

  // The current burst beat is the last one when the owner releases the lock
  // or the beat count reaches MAX_BURST.
  always_comb begin
    if (!reqLock[owner_q] || ((burst_cnt_q + 4'd1) >= 4'(MAX_BURST))) begin
      burst_last_s = 1'b1;
    end else begin
      burst_last_s = 1'b0;
    end
  end

  assign reqReady = gnt_s;

  // Arbiter FSM together with the registered write stage and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      burst_cnt_q    <= 4'd0;
      data_q         <= '0;
      reg_q          <= '0;
      we_q           <= 1'b0;
      burst_active_q <= 1'b0;
    end else begin
      we_q <= gnt_found_s;
      if (gnt_found_s) begin
        data_q <= gnt_data_s;
        reg_q  <= gnt_reg_s;
      end
      case (state_q)
        ARB_IDLE: begin
          if (gnt_found_s) begin
            rr_ptr_q <= rr_next_s;
            if (reqLock[gnt_idx_s] && (MAX_BURST > 1)) begin
              state_q        <= ARB_BURST;
              owner_q        <= gnt_idx_s;
              burst_cnt_q    <= 4'd1;
              burst_active_q <= 1'b1;
            end
          end
        end
        ARB_BURST: begin
          // rr_ptr_q stays put: it already points past the owner.
          if (!gnt_found_s || burst_last_s) begin
            state_q        <= ARB_IDLE;
            burst_cnt_q    <= 4'd0;
            burst_active_q <= 1'b0;
          end else begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q        <= ARB_IDLE;
          burst_cnt_q    <= 4'd0;
          burst_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign dataIn             = data_q;
  assign dataInRegister     = reg_q;
  assign enableSavingDataIn = we_q;
  assign burstActive        = burst_active_q;

`ifdef REGARB_HAZARD_EN
  // Read-after-write hazard flags for the two register-file read ports.
  always_comb begin
    if (!rst_n) begin
      hazardA = 1'b0;
      hazardB = 1'b0;
    end else begin
      hazardA = (gnt_found_s && (dataOutRegisterA == gnt_reg_s)) ||
                (we_q && (dataOutRegisterA == reg_q));
      hazardB = (gnt_found_s && (dataOutRegisterB == gnt_reg_s)) ||
                (we_q && (dataOutRegisterB == reg_q));
    end
  end
`endif

  regfile_write_arbiter_checker #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .burstCnt    (burst_cnt_q)
  );

endmodule

// -----------------------------------------------------------------------------
// regfile_write_arbiter_checker
//
// Grant-sanity properties for regfile_write_arbiter.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   reqValid    requester valid vector
//   reqReady    grant vector
//   burstCnt    current burst beat count
// -----------------------------------------------------------------------------
module regfile_write_arbiter_checker #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] reqValid,
  input logic [NUM_REQ-1:0] reqReady,
  input logic [3:0]         burstCnt
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(reqReady))
    else $error("regarb: more than one grant");

  a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((reqReady & ~reqValid) == '0))
    else $error("regarb: grant to idle requester");

  a_burst_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (burstCnt <= 4'(MAX_BURST)))
    else $error("regarb: burst count overrun");

endmodule
